// File: rtl/spi_sram_pkg.sv
// Shared definitions for the 23K256-style SPI SRAM responder: instruction codes,
// status-register mode encodings, page geometry and the controller state type.
package spi_sram_pkg;

   localparam logic [7:0] INSTR_READ  = 8'h03;
   localparam logic [7:0] INSTR_WRITE = 8'h02;
   localparam logic [7:0] INSTR_RDSR  = 8'h05;
   localparam logic [7:0] INSTR_WRSR  = 8'h01;

   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_SEQ  = 2'b01;
   localparam logic [1:0] MODE_PAGE = 2'b10;

   localparam int PAGE_SIZE = 32;
   localparam int PAGE_BITS = $clog2(PAGE_SIZE);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INSTR,
      ST_ADDR,
      ST_RDATA,
      ST_WDATA,
      ST_RDSR,
      ST_WRSR,
      ST_IGNORE
   } state_t;

   function automatic state_t decode_instr(input logic [7:0] ins);
      state_t st;
      st = ST_IGNORE;
      case (ins)
         INSTR_READ, INSTR_WRITE: st = ST_ADDR;
         INSTR_RDSR:              st = ST_RDSR;
         INSTR_WRSR:              st = ST_WRSR;
         default:                 st = ST_IGNORE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/spi_sram_slave_pin_sync.sv
// Multi-stage synchroniser with registered rise/fall strobes for one SPI pin.
// Strobes trail the pin by SYNC_STAGES+1 cycles; o_level is aligned with them.
module spi_pin_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
         o_rise <= 1'b0;
         o_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
         r_prev <= r_sync[SYNC_STAGES-1];
         o_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
         o_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
      end
   end

   assign o_level = r_prev;

endmodule

// File: rtl/spi_sram_slave.sv
// SPI responder emulating the 23K256 READ/WRITE/RDSR/WRSR command set over a
// synchronous memory port. Optional HOLD pin support: SPI_SRAM_SLAVE_HOLD_EN.
//
// state     | meaning
// ST_IDLE   | nCS high, waiting for selection
// ST_INSTR  | shifting in the 8-bit instruction
// ST_ADDR   | shifting in the 16-bit address
// ST_RDATA  | driving memory bytes on SO
// ST_WDATA  | collecting bytes, one write strobe per byte
// ST_RDSR   | driving status on SO, repeating
// ST_WRSR   | collecting the new status byte
// ST_IGNORE | SO tri-stated until nCS rises
module spi_sram_slave
   import spi_sram_pkg::*;
#(
   parameter int ADDR_W      = 15,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_sck,
   input  logic              i_ncs,
   input  logic              i_s,
   output logic              o_s,
   output logic              o_s_oe,
`ifdef SPI_SRAM_SLAVE_HOLD_EN
   input  logic              i_nhold,
`endif
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_wdata,
   output logic              o_mem_we,
   output logic              o_mem_re,
   input  logic [7:0]        i_mem_rdata,
   output logic [7:0]        o_status
);

   logic w_sck_lvl, w_sck_rise, w_sck_fall;
   logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;
   logic w_si, w_si_rise, w_si_fall;
   logic w_hold;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_sck),
      .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_ncs),
      .o_level(w_ncs_lvl), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall));

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_si (
      .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_s),
      .o_level(w_si), .o_rise(w_si_rise), .o_fall(w_si_fall));

   state_t            r_state;
   logic [3:0]        r_bit_cnt;
   logic [15:0]       r_shift_in;
   logic [7:0]        r_shift_out;
   logic [7:0]        r_prefetch;
   logic [7:0]        r_status;
   logic [ADDR_W-1:0] r_addr;
   logic              r_is_read;
   logic              r_drive;
   logic              r_re_pend;

`ifdef SPI_SRAM_SLAVE_HOLD_EN
   logic w_nhold_lvl, w_nhold_rise, w_nhold_fall;
   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nhold (
      .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_nhold),
      .o_level(w_nhold_lvl), .o_rise(w_nhold_rise), .o_fall(w_nhold_fall));
   assign w_hold = ~w_nhold_lvl & ~r_status[0];
   logic w_unused_hold;
   assign w_unused_hold = w_nhold_rise | w_nhold_fall;
`else
   assign w_hold = 1'b0;
`endif

   logic [15:0]       w_shift_next;
   logic [7:0]        w_instr;
   logic [ADDR_W-1:0] w_addr_in;
   logic [ADDR_W-1:0] w_next_addr;
   logic              w_byte_mode;
   logic [7:0]        w_out_src;

   assign w_shift_next = {r_shift_in[14:0], w_si};
   assign w_instr      = w_shift_next[7:0];
   assign w_addr_in    = w_shift_next[ADDR_W-1:0];
   // Mode 11 is reserved and behaves as byte mode.
   assign w_byte_mode  = (r_status[7] == r_status[6]);
   assign w_next_addr  = (r_status[7:6] == MODE_PAGE)
                       ? {r_addr[ADDR_W-1:PAGE_BITS], r_addr[PAGE_BITS-1:0] + PAGE_BITS'(1)}
                       : r_addr + ADDR_W'(1);
   assign w_out_src    = (r_state == ST_RDSR) ? r_status : r_prefetch;
   assign o_status     = r_status;

   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, w_sck_lvl, w_ncs_lvl, w_si_rise, w_si_fall, w_shift_next};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_shift_in  <= '0;
         r_shift_out <= '0;
         r_prefetch  <= '0;
         r_status    <= '0;
         r_addr      <= '0;
         r_is_read   <= 1'b0;
         r_drive     <= 1'b0;
         r_re_pend   <= 1'b0;
         o_s         <= 1'b0;
         o_s_oe      <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_we    <= 1'b0;
         o_mem_re    <= 1'b0;
      end else begin
         o_mem_we  <= 1'b0;
         o_mem_re  <= 1'b0;
         r_re_pend <= o_mem_re;
         if (r_re_pend) r_prefetch <= i_mem_rdata;
         o_s_oe <= r_drive & ~w_hold;

         if (w_ncs_rise) begin
            r_state <= ST_IDLE;
            r_drive <= 1'b0;
            o_s_oe  <= 1'b0;
            o_s     <= 1'b0;
         end else if (w_ncs_fall) begin
            r_state   <= ST_INSTR;
            r_bit_cnt <= '0;
            r_drive   <= 1'b0;
         end else if (w_hold) begin
            r_state <= r_state;
         end else if (w_sck_rise) begin
            r_shift_in <= w_shift_next;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            case (r_state)
               ST_INSTR: if (r_bit_cnt == 4'd7) begin
                  r_bit_cnt <= '0;
                  r_state   <= decode_instr(w_instr);
                  r_is_read <= (w_instr == INSTR_READ);
                  r_drive   <= (w_instr == INSTR_RDSR);
               end
               ST_ADDR: if (r_bit_cnt == 4'd15) begin
                  r_bit_cnt <= '0;
                  r_addr    <= w_addr_in;
                  if (r_is_read) begin
                     r_state    <= ST_RDATA;
                     r_drive    <= 1'b1;
                     o_mem_re   <= 1'b1;
                     o_mem_addr <= w_addr_in;
                  end else begin
                     r_state <= ST_WDATA;
                  end
               end
               // Last bit of a read byte: fetch the following byte into the prefetch buffer.
               ST_RDATA: if (r_bit_cnt == 4'd7) begin
                  r_bit_cnt <= '0;
                  if (w_byte_mode) begin
                     r_state <= ST_IGNORE;
                     r_drive <= 1'b0;
                  end else begin
                     r_addr     <= w_next_addr;
                     o_mem_addr <= w_next_addr;
                     o_mem_re   <= 1'b1;
                  end
               end
               ST_WDATA: if (r_bit_cnt == 4'd7) begin
                  r_bit_cnt   <= '0;
                  o_mem_we    <= 1'b1;
                  o_mem_wdata <= w_shift_next[7:0];
                  o_mem_addr  <= r_addr;
                  if (w_byte_mode) r_state <= ST_IGNORE;
                  else             r_addr  <= w_next_addr;
               end
               ST_RDSR: if (r_bit_cnt == 4'd7) r_bit_cnt <= '0;
               ST_WRSR: if (r_bit_cnt == 4'd7) begin
                  r_bit_cnt <= '0;
                  r_status  <= {w_shift_next[7:6], 5'b0, w_shift_next[0]};
                  r_state   <= ST_IGNORE;
               end
               default: r_bit_cnt <= '0;
            endcase
         end else if (w_sck_fall) begin
            if (r_state == ST_RDATA || r_state == ST_RDSR) begin
               if (r_bit_cnt == 4'd0) begin
                  o_s         <= w_out_src[7];
                  r_shift_out <= {w_out_src[6:0], 1'b0};
               end else begin
                  o_s         <= r_shift_out[7];
                  r_shift_out <= {r_shift_out[6:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_sram_slave.sv
// Self-checking bench for spi_sram_slave: acts as SPI master and backing memory,
// compares transfers against a behavioural model of the 23K256 command set.
module tb_spi_sram_slave;

   localparam int H = 6;

   logic        clk = 1'b0;
   logic        rst, sck, ncs, si;
   logic        s_out, s_oe;
   logic [14:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata, status;
   logic        mem_we, mem_re;
`ifdef SPI_SRAM_SLAVE_HOLD_EN
   logic        nhold = 1'b1;
`endif

   always #5 clk = ~clk;

   spi_sram_slave #(.ADDR_W(15), .SYNC_STAGES(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_ncs(ncs), .i_s(si),
      .o_s(s_out), .o_s_oe(s_oe),
`ifdef SPI_SRAM_SLAVE_HOLD_EN
      .i_nhold(nhold),
`endif
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
      .o_mem_re(mem_re), .i_mem_rdata(mem_rdata), .o_status(status));

   logic [7:0]  mem     [0:32767];
   logic [7:0]  ref_mem [0:32767];
   logic [7:0]  ref_status;
   logic [14:0] re_q[$];
   logic [22:0] we_q[$];
   logic [14:0] exp_re[$];
   logic [22:0] exp_we[$];
   logic [7:0]  rx_buf [0:15];
   logic        rx_all [0:15];
   logic        rx_any [0:15];
   logic [7:0]  wr_buf [0:15];
   int          n_checks = 0;
   int          n_errors = 0;

   // Memory responder and bus monitor.
   initial begin
      mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (mem_re) begin
            mem_rdata = mem[mem_addr];
            re_q.push_back(mem_addr);
         end
         if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            we_q.push_back({mem_addr, mem_wdata});
         end
      end
   end

   function automatic bit ref_byte_mode(input logic [7:0] st);
      return (st[7:6] == 2'b00) || (st[7:6] == 2'b11);
   endfunction

   function automatic logic [14:0] ref_adv(input logic [14:0] a, input logic [7:0] st);
      int ai;
      ai = int'(a);
      if (st[7:6] == 2'b10) return 15'((ai / 32) * 32 + ((ai % 32) + 1) % 32);
      return 15'((ai + 1) % 32768);
   endfunction

   task automatic model_read(input logic [15:0] a, input int n);
      logic [14:0] cur;
      cur = a[14:0];
      exp_re.delete();
      exp_re.push_back(cur);
      for (int k = 1; k <= n; k++) begin
         if (ref_byte_mode(ref_status)) break;
         cur = ref_adv(cur, ref_status);
         exp_re.push_back(cur);
      end
   endtask

   task automatic model_write(input logic [15:0] a, input int n);
      logic [14:0] cur;
      cur = a[14:0];
      exp_we.delete();
      for (int k = 0; k < n; k++) begin
         exp_we.push_back({cur, wr_buf[k]});
         ref_mem[cur] = wr_buf[k];
         if (ref_byte_mode(ref_status)) break;
         cur = ref_adv(cur, ref_status);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cs_begin();
      re_q.delete();
      we_q.delete();
      ncs = 1'b0;
      tick(2 * H);
   endtask

   task automatic cs_end();
      tick(H);
      ncs = 1'b1;
      tick(3 * H);
   endtask

   task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                            output logic drv_all, output logic drv_any);
      rx = 8'h00;
      drv_all = 1'b1;
      drv_any = 1'b0;
      for (int i = 7; i >= 8 - nbits; i--) begin
         si = tx[i];
         tick(H);
         rx[i]   = s_out;
         drv_all = drv_all & s_oe;
         drv_any = drv_any | s_oe;
         sck = 1'b1;
         tick(H);
         sck = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] tx);
      logic [7:0] rx;
      logic       a, b;
      xfer_bits(tx, 8, rx, a, b);
   endtask

   task automatic cmd_wrsr(input logic [7:0] v);
      cs_begin();
      xfer(8'h01);
      xfer(v);
      cs_end();
      ref_status = v & 8'hC1;
   endtask

   task automatic cmd_read(input logic [15:0] a, input int n);
      cs_begin();
      xfer(8'h03);
      xfer(a[15:8]);
      xfer(a[7:0]);
      for (int k = 0; k < n; k++) xfer_bits(8'h00, 8, rx_buf[k], rx_all[k], rx_any[k]);
      cs_end();
   endtask

   task automatic cmd_write(input logic [15:0] a, input int n);
      cs_begin();
      xfer(8'h02);
      xfer(a[15:8]);
      xfer(a[7:0]);
      for (int k = 0; k < n; k++) xfer(wr_buf[k]);
      cs_end();
   endtask

   task automatic test_reset();
      n_checks++; if (s_out !== 1'b0) begin n_errors++; $display("FAIL reset_o_s got=%b exp=0", s_out); end
      n_checks++; if (s_oe !== 1'b0) begin n_errors++; $display("FAIL reset_o_s_oe got=%b exp=0", s_oe); end
      n_checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin n_errors++; $display("FAIL reset_strobes got we=%b re=%b exp=0", mem_we, mem_re); end
      n_checks++; if (mem_addr !== 15'h0 || mem_wdata !== 8'h00) begin n_errors++; $display("FAIL reset_bus got addr=%h wdata=%h exp=0", mem_addr, mem_wdata); end
      n_checks++; if (status !== 8'h00) begin n_errors++; $display("FAIL reset_status got=%h exp=00", status); end
   endtask

   task automatic test_wrsr_write();
      logic [7:0] rx;
      logic       da, dn;
      cmd_wrsr(8'h40);
      n_checks++; if (status !== 8'h40) begin n_errors++; $display("FAIL wrsr_status got=%h exp=40", status); end
      wr_buf[0] = 8'hA5;
      wr_buf[1] = 8'h5A;
      model_write(16'h0010, 2);
      cmd_write(16'h0010, 2);
      n_checks++;
      if (we_q.size() != exp_we.size()) begin
         n_errors++; $display("FAIL seq_write_count got=%0d exp=%0d", we_q.size(), exp_we.size());
      end else begin
         for (int k = 0; k < exp_we.size(); k++) begin
            n_checks++;
            if (we_q[k] !== exp_we[k]) begin n_errors++; $display("FAIL seq_write_%0d got=%h exp=%h", k, we_q[k], exp_we[k]); end
         end
      end
      cs_begin();
      xfer(8'h05);
      for (int k = 0; k < 3; k++) begin
         xfer_bits(8'h00, 8, rx, da, dn);
         n_checks++;
         if (rx !== 8'h40 || da !== 1'b1) begin n_errors++; $display("FAIL rdsr_%0d got=%h oe=%b exp=40 oe=1", k, rx, da); end
      end
      cs_end();
      cmd_wrsr(8'hFF);
      n_checks++; if (status !== 8'hC1) begin n_errors++; $display("FAIL wrsr_mask got=%h exp=c1", status); end
   endtask

   task automatic test_reads();
      logic [7:0]  modes [0:2];
      logic [15:0] addrs [0:2];
      modes[0] = 8'h00; addrs[0] = 16'h0010;
      modes[1] = 8'h80; addrs[1] = 16'h001F;
      modes[2] = 8'h40; addrs[2] = 16'h7FFF;
      mem[16'h0010] = 8'h3C;
      ref_mem[16'h0010] = 8'h3C;
      for (int t = 0; t < 3; t++) begin
         cmd_wrsr(modes[t]);
         model_read(addrs[t], 2);
         cmd_read(addrs[t], 2);
         n_checks++;
         if (re_q.size() != exp_re.size()) begin
            n_errors++; $display("FAIL read%0d_re_count got=%0d exp=%0d", t, re_q.size(), exp_re.size());
         end else begin
            for (int k = 0; k < exp_re.size(); k++) begin
               n_checks++;
               if (re_q[k] !== exp_re[k]) begin n_errors++; $display("FAIL read%0d_re_addr%0d got=%h exp=%h", t, k, re_q[k], exp_re[k]); end
            end
         end
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (k >= exp_re.size()) begin
               if (rx_any[k] !== 1'b0) begin n_errors++; $display("FAIL read%0d_tristate%0d got oe=%b exp=0", t, k, rx_any[k]); end
            end else if (rx_buf[k] !== ref_mem[exp_re[k]] || rx_all[k] !== 1'b1) begin
               n_errors++; $display("FAIL read%0d_data%0d got=%h oe=%b exp=%h oe=1", t, k, rx_buf[k], rx_all[k], ref_mem[exp_re[k]]);
            end
         end
      end
   endtask

   task automatic test_abort_write();
      logic [7:0] rx;
      logic       da, dn;
      cmd_wrsr(8'h00);
      cs_begin();
      xfer(8'h02);
      xfer(8'h00);
      xfer(8'h04);
      xfer_bits(8'hFF, 5, rx, da, dn);
      cs_end();
      n_checks++; if (we_q.size() != 0) begin n_errors++; $display("FAIL abort_write_we got=%0d exp=0", we_q.size()); end
      cs_begin();
      xfer(8'h05);
      xfer_bits(8'h00, 8, rx, da, dn);
      cs_end();
      n_checks++; if (rx !== ref_status || da !== 1'b1) begin n_errors++; $display("FAIL abort_next_rdsr got=%h oe=%b exp=%h oe=1", rx, da, ref_status); end
      cmd_read(16'h0004, 1);
      n_checks++; if (rx_buf[0] !== ref_mem[4] || rx_all[0] !== 1'b1) begin n_errors++; $display("FAIL abort_next_read got=%h exp=%h", rx_buf[0], ref_mem[4]); end
   endtask

   task automatic test_random();
      logic [15:0] a, last_a;
      int          n;
      last_a = 16'h0000;
      for (int it = 0; it < 24; it++) begin
         cmd_wrsr(8'($urandom));
         n_checks++; if (status !== ref_status) begin n_errors++; $display("FAIL rnd%0d_status got=%h exp=%h", it, status, ref_status); end
         a = ($urandom_range(0, 1) == 1) ? last_a : 16'($urandom);
         if ($urandom_range(0, 3) == 0) a = {a[15], 15'h7FFE + 15'($urandom_range(0, 1))};
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < n; k++) wr_buf[k] = 8'($urandom);
            model_write(a, n);
            cmd_write(a, n);
            n_checks++;
            if (we_q.size() != exp_we.size()) begin
               n_errors++; $display("FAIL rnd%0d_we_count got=%0d exp=%0d", it, we_q.size(), exp_we.size());
            end else begin
               for (int k = 0; k < exp_we.size(); k++) begin
                  n_checks++;
                  if (we_q[k] !== exp_we[k]) begin n_errors++; $display("FAIL rnd%0d_we%0d got=%h exp=%h", it, k, we_q[k], exp_we[k]); end
               end
            end
            last_a = a;
         end else begin
            model_read(a, n);
            cmd_read(a, n);
            for (int k = 0; k < n; k++) begin
               n_checks++;
               if (k >= exp_re.size()) begin
                  if (rx_any[k] !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_tristate%0d got oe=%b exp=0", it, k, rx_any[k]); end
               end else if (rx_buf[k] !== ref_mem[exp_re[k]] || rx_all[k] !== 1'b1) begin
                  n_errors++; $display("FAIL rnd%0d_rd%0d got=%h oe=%b exp=%h oe=1", it, k, rx_buf[k], rx_all[k], ref_mem[exp_re[k]]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] rx;
      logic       da, dn;
      cmd_wrsr(8'h80);
      cs_begin();
      xfer(8'h03);
      xfer(8'h01);
      xfer(8'h00);
      xfer_bits(8'h00, 3, rx, da, dn);
      rst = 1'b1;
      #1;
      ref_status = 8'h00;
      n_checks++; if (s_out !== 1'b0 || s_oe !== 1'b0) begin n_errors++; $display("FAIL midrst_so got s=%b oe=%b exp=0", s_out, s_oe); end
      n_checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 15'h0 || mem_wdata !== 8'h00) begin
         n_errors++; $display("FAIL midrst_bus got we=%b re=%b addr=%h wd=%h exp=0", mem_we, mem_re, mem_addr, mem_wdata);
      end
      n_checks++; if (status !== 8'h00) begin n_errors++; $display("FAIL midrst_status got=%h exp=00", status); end
      tick(3);
      rst = 1'b0;
      cs_end();
      cs_begin();
      xfer(8'h9F);
      for (int k = 0; k < 2; k++) begin
         xfer_bits(8'h00, 8, rx, da, dn);
         n_checks++; if (dn !== 1'b0) begin n_errors++; $display("FAIL ignore_oe%0d got=%b exp=0", k, dn); end
      end
      cs_end();
      n_checks++; if (re_q.size() != 0 || we_q.size() != 0) begin n_errors++; $display("FAIL ignore_strobes got re=%0d we=%0d exp=0", re_q.size(), we_q.size()); end
   endtask

   initial begin
      rst = 1'b1;
      sck = 1'b0;
      ncs = 1'b1;
      si  = 1'b0;
      ref_status = 8'h00;
      for (int i = 0; i < 32768; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      tick(5);
      rst = 1'b0;
      tick(10);
      test_reset();
      test_wrsr_write();
      test_reads();
      test_abort_write();
      test_random();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
